// File: rtl/comm_pkg.sv
// rtl/comm_pkg.sv - shared AXI-Stream width constants and clog2 helper
package comm_pkg;

    localparam int AXIS_DATA_WIDTH = 32;
    localparam int AXIS_LAST_WIDTH = 1;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// rtl/axis_fifo_ram.sv - FIFO storage array, synchronous write, asynchronous read
module axis_fifo_ram
    import comm_pkg::*;
#(
    parameter int WIDTH = AXIS_DATA_WIDTH + AXIS_LAST_WIDTH,
    parameter int DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      wr_en,
    input  logic [clog2(DEPTH)-1:0]   wr_addr,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic [clog2(DEPTH)-1:0]   rd_addr,
    output logic [WIDTH-1:0]          rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Contents are deliberately never reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/axis_fifo.sv
// rtl/axis_fifo.sv - AXI-Stream FIFO with word and store-and-forward packet modes
module axis_fifo
    import comm_pkg::*;
#(
    parameter int WIDTH        = AXIS_DATA_WIDTH,
    parameter int DEPTH        = 16,
    parameter int ALMOST_FULL  = 12,
    parameter int ALMOST_EMPTY = 4,
    parameter int PACKET_MODE  = 0
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [WIDTH-1:0]        s_axis_tdata,
    input  logic                    s_axis_tlast,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    output logic [WIDTH-1:0]        m_axis_tdata,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [clog2(DEPTH):0]   level,
    output logic                    almost_full,
    output logic                    almost_empty
);

    localparam int AW = clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = WIDTH + AXIS_LAST_WIDTH;
    localparam logic [PW-1:0] AF_TH = PW'(ALMOST_FULL);
    localparam logic [PW-1:0] AE_TH = PW'(ALMOST_EMPTY);
    localparam logic [PW-1:0] ONE   = PW'(1);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] pkt_cnt;
    logic          empty;
    logic          full;
    logic          wr_hs;
    logic          rd_hs;
    logic          wr_last;
    logic          rd_last;
    logic [EW-1:0] rd_entry;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    assign s_axis_tready = !full;
    // Packet mode only exposes data once a complete packet is stored.
    assign m_axis_tvalid = (PACKET_MODE != 0) ? (pkt_cnt != '0) : !empty;

    assign wr_hs   = s_axis_tvalid && !full;
    assign rd_hs   = m_axis_tvalid && m_axis_tready;
    assign wr_last = wr_hs && s_axis_tlast;
    assign rd_last = rd_hs && m_axis_tlast;

    assign level        = wr_ptr - rd_ptr;
    assign almost_full  = (level >= AF_TH);
    assign almost_empty = (level <= AE_TH);

    assign m_axis_tdata = rd_entry[WIDTH-1:0];
    assign m_axis_tlast = rd_entry[WIDTH];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            pkt_cnt <= '0;
        end else begin
            if (wr_hs) begin
                wr_ptr <= wr_ptr + ONE;
            end
            if (rd_hs) begin
                rd_ptr <= rd_ptr + ONE;
            end
            case ({wr_last, rd_last})
                2'b10:   pkt_cnt <= pkt_cnt + ONE;
                2'b01:   pkt_cnt <= pkt_cnt - ONE;
                default: pkt_cnt <= pkt_cnt;
            endcase
        end
    end

    axis_fifo_ram #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (aclk),
        .wr_en   (wr_hs),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data ({s_axis_tlast, s_axis_tdata}),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (rd_entry)
    );

endmodule

// File: tb/tb_axis_fifo.sv
// tb/tb_axis_fifo.sv - directed and scoreboard bench for axis_fifo in three configurations
module tb_axis_fifo;

    logic clk;
    logic resetn;
    int   checks;
    int   errors;

    // word mode, default parameters
    logic [31:0] w_sdata;
    logic        w_slast, w_svalid, w_sready;
    logic [31:0] w_mdata;
    logic        w_mlast, w_mvalid, w_mready;
    logic [4:0]  w_level;
    logic        w_af, w_ae;

    // packet mode, default sizes
    logic [31:0] p_sdata;
    logic        p_slast, p_svalid, p_sready;
    logic [31:0] p_mdata;
    logic        p_mlast, p_mvalid, p_mready;
    logic [4:0]  p_level;
    logic        p_af, p_ae;

    // small word-mode FIFO for randomized traffic
    logic [7:0]  r_sdata;
    logic        r_slast, r_svalid, r_sready;
    logic [7:0]  r_mdata;
    logic        r_mlast, r_mvalid, r_mready;
    logic [2:0]  r_level;
    logic        r_af, r_ae;

    axis_fifo u_word (
        .aclk (clk), .aresetn (resetn),
        .s_axis_tdata (w_sdata), .s_axis_tlast (w_slast),
        .s_axis_tvalid (w_svalid), .s_axis_tready (w_sready),
        .m_axis_tdata (w_mdata), .m_axis_tlast (w_mlast),
        .m_axis_tvalid (w_mvalid), .m_axis_tready (w_mready),
        .level (w_level), .almost_full (w_af), .almost_empty (w_ae)
    );

    axis_fifo #(.PACKET_MODE (1)) u_pkt (
        .aclk (clk), .aresetn (resetn),
        .s_axis_tdata (p_sdata), .s_axis_tlast (p_slast),
        .s_axis_tvalid (p_svalid), .s_axis_tready (p_sready),
        .m_axis_tdata (p_mdata), .m_axis_tlast (p_mlast),
        .m_axis_tvalid (p_mvalid), .m_axis_tready (p_mready),
        .level (p_level), .almost_full (p_af), .almost_empty (p_ae)
    );

    axis_fifo #(.WIDTH (8), .DEPTH (4), .ALMOST_FULL (3), .ALMOST_EMPTY (1)) u_small (
        .aclk (clk), .aresetn (resetn),
        .s_axis_tdata (r_sdata), .s_axis_tlast (r_slast),
        .s_axis_tvalid (r_svalid), .s_axis_tready (r_sready),
        .m_axis_tdata (r_mdata), .m_axis_tlast (r_mlast),
        .m_axis_tvalid (r_mvalid), .m_axis_tready (r_mready),
        .level (r_level), .almost_full (r_af), .almost_empty (r_ae)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (w_sready !== 1'b1 || w_mvalid !== 1'b0 || w_level !== 5'd0 || w_af !== 1'b0 || w_ae !== 1'b1) begin
            errors++;
            $display("FAIL reset_word_during: tready=%b tvalid=%b level=%0d af=%b ae=%b expected 1 0 0 0 1",
                     w_sready, w_mvalid, w_level, w_af, w_ae);
        end
        step();
        #3 resetn = 1'b1;
        step();
        checks++;
        if (w_sready !== 1'b1 || w_mvalid !== 1'b0 || w_level !== 5'd0 || w_af !== 1'b0 || w_ae !== 1'b1) begin
            errors++;
            $display("FAIL reset_word_after: tready=%b tvalid=%b level=%0d af=%b ae=%b expected 1 0 0 0 1",
                     w_sready, w_mvalid, w_level, w_af, w_ae);
        end
        checks++;
        if (p_mvalid !== 1'b0 || p_sready !== 1'b1 || r_level !== 3'd0 || r_ae !== 1'b1 || r_af !== 1'b0) begin
            errors++;
            $display("FAIL reset_others: p_tvalid=%b p_tready=%b r_level=%0d r_ae=%b r_af=%b expected 0 1 0 1 0",
                     p_mvalid, p_sready, r_level, r_ae, r_af);
        end
    endtask

    task automatic test_fill();
        w_mready = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            w_sdata  = 32'(i);
            w_svalid = 1'b1;
            step();
            checks++;
            if (w_level !== 5'(i) || w_af !== (i >= 12) || w_ae !== (i <= 4) || w_sready !== (i < 16)) begin
                errors++;
                $display("FAIL fill_step%0d: level=%0d af=%b ae=%b tready=%b expected level=%0d af=%b ae=%b tready=%b",
                         i, w_level, w_af, w_ae, w_sready, i, (i >= 12), (i <= 4), (i < 16));
            end
        end
        w_sdata = 32'd17;
        step();
        w_svalid = 1'b0;
        checks++;
        if (w_level !== 5'd16 || w_sready !== 1'b0 || w_af !== 1'b1) begin
            errors++;
            $display("FAIL fill_overflow: level=%0d tready=%b af=%b expected 16 0 1", w_level, w_sready, w_af);
        end
        checks++;
        if (w_mvalid !== 1'b1 || w_mdata !== 32'd1) begin
            errors++;
            $display("FAIL fill_hold_head: tvalid=%b data=%0d expected 1 1", w_mvalid, w_mdata);
        end
    endtask

    task automatic test_drain();
        w_mready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            checks++;
            if (w_mvalid !== 1'b1 || w_mdata !== 32'(i)) begin
                errors++;
                $display("FAIL drain_word%0d: tvalid=%b data=%0d expected 1 %0d", i, w_mvalid, w_mdata, i);
            end
            step();
        end
        checks++;
        if (w_mvalid !== 1'b0 || w_level !== 5'd0 || w_ae !== 1'b1 || w_sready !== 1'b1) begin
            errors++;
            $display("FAIL drain_empty: tvalid=%b level=%0d ae=%b tready=%b expected 0 0 1 1",
                     w_mvalid, w_level, w_ae, w_sready);
        end
    endtask

    task automatic test_back_to_back();
        int bad;
        bad = 0;
        w_mready = 1'b1;
        w_svalid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            w_sdata = 32'(1000 + i);
            step();
            checks++;
            if (w_level !== 5'd1 || w_mvalid !== 1'b1 || w_mdata !== 32'(1000 + i)) begin
                errors++;
                bad++;
                if (bad < 5)
                    $display("FAIL stream_word%0d: level=%0d tvalid=%b data=%0d expected 1 1 %0d",
                             i, w_level, w_mvalid, w_mdata, 1000 + i);
            end
        end
        w_svalid = 1'b0;
        step();
        checks++;
        if (w_level !== 5'd0 || w_mvalid !== 1'b0) begin
            errors++;
            $display("FAIL stream_end: level=%0d tvalid=%b expected 0 0", w_level, w_mvalid);
        end
        w_mready = 1'b0;
    endtask

    task automatic test_packet();
        logic [31:0] words [3];
        words[0] = 32'hA;
        words[1] = 32'hB;
        words[2] = 32'hC;
        p_mready = 1'b1;
        p_svalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            p_sdata = words[i];
            p_slast = (i == 2);
            step();
            checks++;
            if (p_mvalid !== (i == 2) || p_level !== 5'(i + 1)) begin
                errors++;
                $display("FAIL pkt_write%0d: tvalid=%b level=%0d expected %b %0d",
                         i, p_mvalid, p_level, (i == 2), i + 1);
            end
        end
        p_svalid = 1'b0;
        p_slast  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (p_mvalid !== 1'b1 || p_mdata !== words[i] || p_mlast !== (i == 2)) begin
                errors++;
                $display("FAIL pkt_read%0d: tvalid=%b data=%h last=%b expected 1 %h %b",
                         i, p_mvalid, p_mdata, p_mlast, words[i], (i == 2));
            end
            step();
        end
        checks++;
        if (p_mvalid !== 1'b0 || p_level !== 5'd0) begin
            errors++;
            $display("FAIL pkt_done: tvalid=%b level=%0d expected 0 0", p_mvalid, p_level);
        end
    endtask

    task automatic test_reset_mid();
        w_mready = 1'b0;
        w_svalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            w_sdata = 32'(200 + i);
            step();
        end
        w_svalid = 1'b0;
        p_svalid = 1'b1;
        p_mready = 1'b0;
        p_sdata  = 32'h77;
        step();
        p_svalid = 1'b0;
        checks++;
        if (w_level !== 5'd5 || p_level !== 5'd1 || p_mvalid !== 1'b0) begin
            errors++;
            $display("FAIL premid_state: w_level=%0d p_level=%0d p_tvalid=%b expected 5 1 0",
                     w_level, p_level, p_mvalid);
        end
        #2 resetn = 1'b0;
        #1;
        checks++;
        if (w_sready !== 1'b1 || w_mvalid !== 1'b0 || w_level !== 5'd0 || w_ae !== 1'b1 || p_level !== 5'd0) begin
            errors++;
            $display("FAIL midreset_async: tready=%b tvalid=%b level=%0d ae=%b p_level=%0d expected 1 0 0 1 0",
                     w_sready, w_mvalid, w_level, w_ae, p_level);
        end
        step();
        #2 resetn = 1'b1;
        step();
        w_sdata  = 32'hA5;
        w_svalid = 1'b1;
        step();
        w_svalid = 1'b0;
        checks++;
        if (w_mvalid !== 1'b1 || w_mdata !== 32'hA5 || w_level !== 5'd1) begin
            errors++;
            $display("FAIL postreset_first: tvalid=%b data=%h level=%0d expected 1 a5 1",
                     w_mvalid, w_mdata, w_level);
        end
        p_sdata  = 32'h5A;
        p_slast  = 1'b1;
        p_svalid = 1'b1;
        p_mready = 1'b1;
        step();
        p_svalid = 1'b0;
        p_slast  = 1'b0;
        checks++;
        if (p_mvalid !== 1'b1 || p_mdata !== 32'h5A || p_mlast !== 1'b1) begin
            errors++;
            $display("FAIL postreset_pkt: tvalid=%b data=%h last=%b expected 1 5a 1",
                     p_mvalid, p_mdata, p_mlast);
        end
    endtask

    task automatic test_random();
        logic [8:0] sb [$];
        int writes;
        int reads;
        int bad;
        logic do_wr;
        logic do_rd;
        writes = 0;
        reads  = 0;
        bad    = 0;
        for (int cyc = 0; cyc < 20000 && reads < 1000; cyc++) begin
            checks++;
            if (r_level !== 3'(sb.size()) || r_sready !== (sb.size() < 4) || r_mvalid !== (sb.size() > 0) ||
                r_af !== (sb.size() >= 3) || r_ae !== (sb.size() <= 1)) begin
                errors++;
                bad++;
                if (bad < 5)
                    $display("FAIL rand_flags cyc%0d: level=%0d tready=%b tvalid=%b af=%b ae=%b expected level=%0d",
                             cyc, r_level, r_sready, r_mvalid, r_af, r_ae, sb.size());
            end
            if (sb.size() > 0) begin
                checks++;
                if ({r_mlast, r_mdata} !== sb[0]) begin
                    errors++;
                    bad++;
                    if (bad < 5)
                        $display("FAIL rand_data cyc%0d: got %h expected %h", cyc, {r_mlast, r_mdata}, sb[0]);
                end
            end
            r_svalid = (writes < 1000) && ($urandom_range(0, 1) == 1);
            r_mready = ($urandom_range(0, 1) == 1);
            r_sdata  = 8'($urandom_range(0, 255));
            r_slast  = ($urandom_range(0, 3) == 0);
            do_wr = r_svalid && (sb.size() < 4);
            do_rd = r_mready && (sb.size() > 0);
            step();
            if (do_rd) begin
                void'(sb.pop_front());
                reads++;
            end
            if (do_wr) begin
                sb.push_back({r_slast, r_sdata});
                writes++;
            end
        end
        r_svalid = 1'b0;
        r_mready = 1'b0;
        checks++;
        if (reads != 1000) begin
            errors++;
            $display("FAIL rand_timeout: read %0d words, expected 1000", reads);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        resetn = 1'b0;
        w_sdata = '0; w_slast = 1'b0; w_svalid = 1'b0; w_mready = 1'b0;
        p_sdata = '0; p_slast = 1'b0; p_svalid = 1'b0; p_mready = 1'b0;
        r_sdata = '0; r_slast = 1'b0; r_svalid = 1'b0; r_mready = 1'b0;
        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_packet();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
